// File: rtl/scene_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scene_pkg
// Contents : Fixed-point constants, sphere record, default scene and scan states
// Revision : 1.0
// ============================================================================
package scene_pkg;

   localparam int COORD_W_DEF = 32;
   localparam int FRAC_W_DEF  = 24;
   localparam int MAT_W_DEF   = 3;
   localparam int N_DEFAULT   = 3;

   localparam logic signed [COORD_W_DEF-1:0] ONE_FX = COORD_W_DEF'(1) << FRAC_W_DEF;

   typedef struct packed {
      logic [3*COORD_W_DEF-1:0] center;   // {z,y,x}
      logic [COORD_W_DEF-1:0]   r2;
      logic [MAT_W_DEF-1:0]     mat;
      logic                     en;
   } sphere_t;

   localparam sphere_t DEFAULT_SCENE [N_DEFAULT] = '{
      '{center: '0, r2: ONE_FX, mat: 3'd0, en: 1'b1},
      '{center: {{(2*COORD_W_DEF){1'b0}}, COORD_W_DEF'(2*ONE_FX)},
        r2: ONE_FX >>> 1, mat: 3'd1, en: 1'b1},
      '{center: {{(2*COORD_W_DEF){1'b0}}, COORD_W_DEF'(-(2*ONE_FX))},
        r2: ONE_FX >>> 1, mat: 3'd2, en: 1'b1}
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEEK = 2'd1,
      ST_HOLD = 2'd2,
      ST_FIN  = 2'd3
   } scan_state_t;

   function automatic sphere_t default_entry(input int idx);
      sphere_t s;
      s = '0;
      if (idx >= 0 && idx < N_DEFAULT) s = DEFAULT_SCENE[idx[1:0]];
      return s;
   endfunction

   // Re-express a default-format fixed-point value with a different fraction width.
   function automatic logic [63:0] rescale(input logic [COORD_W_DEF-1:0] v, input int frac_w);
      logic signed [63:0] w;
      w = 64'(signed'(v));
      return 64'((w <<< frac_w) >>> FRAC_W_DEF);
   endfunction

endpackage
`default_nettype wire

// File: rtl/scene_scan_fsm.sv
`default_nettype none
// ============================================================================
// Module   : scene_scan_fsm
// Contents : Walks the object table and streams enabled entries over valid/ready
// Revision : 1.0
// ============================================================================
module scene_scan_fsm
   import scene_pkg::*;
#(
   parameter int N_OBJ   = 8,
   parameter int COORD_W = COORD_W_DEF,
   parameter int MAT_W   = MAT_W_DEF,
   parameter int ID_W    = $clog2(N_OBJ)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 scan_start,
   input  logic                 s_ready,
   output logic [ID_W-1:0]      idx,
   input  logic [3*COORD_W-1:0] ent_center,
   input  logic [COORD_W-1:0]   ent_r2,
   input  logic [MAT_W-1:0]     ent_mat,
   input  logic                 ent_en,
   output logic                 scan_busy,
   output logic                 scan_done,
   output logic                 s_valid,
   output logic [ID_W-1:0]      s_id,
   output logic [3*COORD_W-1:0] s_center,
   output logic [COORD_W-1:0]   s_r2,
   output logic [MAT_W-1:0]     s_mat
);

   scan_state_t     r_state;
   logic [ID_W-1:0] r_idx;
   logic            w_last;

   assign idx    = r_idx;
   assign w_last = (r_idx == ID_W'(N_OBJ - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         scan_busy <= 1'b0;
         scan_done <= 1'b0;
         s_valid   <= 1'b0;
         s_id      <= '0;
         s_center  <= '0;
         s_r2      <= '0;
         s_mat     <= '0;
      end else begin
         scan_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (scan_start) begin
                  r_state   <= ST_SEEK;
                  r_idx     <= '0;
                  scan_busy <= 1'b1;
               end
            end
            ST_SEEK: begin
               // The held beat is a private copy, so later table writes cannot disturb it.
               if (ent_en) begin
                  s_valid  <= 1'b1;
                  s_id     <= r_idx;
                  s_center <= ent_center;
                  s_r2     <= ent_r2;
                  s_mat    <= ent_mat;
                  r_state  <= ST_HOLD;
               end else if (w_last) begin
                  r_state   <= ST_FIN;
                  scan_busy <= 1'b0;
                  scan_done <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            ST_HOLD: begin
               if (s_ready) begin
                  s_valid <= 1'b0;
                  if (w_last) begin
                     r_state   <= ST_FIN;
                     scan_busy <= 1'b0;
                     scan_done <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= ST_SEEK;
                  end
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/scene_object_table.sv
`default_nettype none
// ============================================================================
// Module   : scene_object_table
// Contents : Writable sphere table with registered random read and a scan stream
// Revision : 1.0
// ============================================================================
module scene_object_table
   import scene_pkg::*;
#(
   parameter int N_OBJ   = 8,
   parameter int COORD_W = COORD_W_DEF,
   parameter int FRAC_W  = FRAC_W_DEF,
   parameter int MAT_W   = MAT_W_DEF,
   parameter int ID_W    = $clog2(N_OBJ)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ID_W-1:0]      rd_id,
   output logic [3*COORD_W-1:0] rd_center,
   output logic [COORD_W-1:0]   rd_r2,
   output logic [MAT_W-1:0]     rd_mat,
   output logic                 rd_hit,
   input  logic                 wr_en,
   input  logic [ID_W-1:0]      wr_id,
   input  logic [3*COORD_W-1:0] wr_center,
   input  logic [COORD_W-1:0]   wr_r2,
   input  logic [MAT_W-1:0]     wr_mat,
   input  logic                 wr_enable,
   input  logic                 scan_start,
   output logic                 scan_busy,
   output logic                 scan_done,
   output logic                 s_valid,
   input  logic                 s_ready,
   output logic [ID_W-1:0]      s_id,
   output logic [3*COORD_W-1:0] s_center,
   output logic [COORD_W-1:0]   s_r2,
   output logic [MAT_W-1:0]     s_mat
);

   function automatic logic [3*COORD_W-1:0] def_center(input int idx);
      sphere_t              s;
      logic [3*COORD_W-1:0] c;
      s = default_entry(idx);
      for (int a = 0; a < 3; a++)
         c[a*COORD_W +: COORD_W] = COORD_W'(rescale(s.center[a*COORD_W_DEF +: COORD_W_DEF], FRAC_W));
      return c;
   endfunction

   function automatic logic [COORD_W-1:0] def_r2(input int idx);
      sphere_t s;
      s = default_entry(idx);
      return COORD_W'(rescale(s.r2, FRAC_W));
   endfunction

   function automatic logic [MAT_W-1:0] def_mat(input int idx);
      sphere_t s;
      s = default_entry(idx);
      return MAT_W'(s.mat);
   endfunction

   function automatic logic def_en(input int idx);
      sphere_t s;
      s = default_entry(idx);
      return s.en;
   endfunction

   logic [3*COORD_W-1:0] r_center [N_OBJ];
   logic [COORD_W-1:0]   r_r2     [N_OBJ];
   logic [MAT_W-1:0]     r_mat    [N_OBJ];
   logic                 r_en     [N_OBJ];

   logic                 w_wr_ok;
   logic                 w_rd_hit;
   logic [ID_W-1:0]      w_scan_idx;

   // Indices past the last entry only exist when N_OBJ is not a power of two.
   assign w_wr_ok  = (32'(wr_id) < N_OBJ);
   assign w_rd_hit = (32'(rd_id) < N_OBJ) && r_en[rd_id];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_OBJ; i++) begin
            r_center[i] <= def_center(i);
            r_r2[i]     <= def_r2(i);
            r_mat[i]    <= def_mat(i);
            r_en[i]     <= def_en(i);
         end
      end else if (wr_en && w_wr_ok) begin
         r_center[wr_id] <= wr_center;
         r_r2[wr_id]     <= wr_r2;
         r_mat[wr_id]    <= wr_mat;
         r_en[wr_id]     <= wr_enable;
      end
   end

   // Sampling the table before this edge's write gives read-before-write ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_center <= def_center(0);
         rd_r2     <= def_r2(0);
         rd_mat    <= def_mat(0);
         rd_hit    <= def_en(0);
      end else if (w_rd_hit) begin
         rd_center <= r_center[rd_id];
         rd_r2     <= r_r2[rd_id];
         rd_mat    <= r_mat[rd_id];
         rd_hit    <= 1'b1;
      end else begin
         rd_center <= '1;
         rd_r2     <= '1;
         rd_mat    <= '1;
         rd_hit    <= 1'b0;
      end
   end

   scene_scan_fsm #(
      .N_OBJ   (N_OBJ),
      .COORD_W (COORD_W),
      .MAT_W   (MAT_W),
      .ID_W    (ID_W)
   ) u_scan (
      .clk        (clk),
      .rst        (rst),
      .scan_start (scan_start),
      .s_ready    (s_ready),
      .idx        (w_scan_idx),
      .ent_center (r_center[w_scan_idx]),
      .ent_r2     (r_r2[w_scan_idx]),
      .ent_mat    (r_mat[w_scan_idx]),
      .ent_en     (r_en[w_scan_idx]),
      .scan_busy  (scan_busy),
      .scan_done  (scan_done),
      .s_valid    (s_valid),
      .s_id       (s_id),
      .s_center   (s_center),
      .s_r2       (s_r2),
      .s_mat      (s_mat)
   );

endmodule
`default_nettype wire

// File: tb/tb_scene_object_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_scene_object_table
// Contents : Randomised self-checking bench for scene_object_table
// Revision : 1.0
// ============================================================================
module tb_scene_object_table;

   localparam int N_OBJ   = 8;
   localparam int COORD_W = 32;
   localparam int MAT_W   = 3;
   localparam int ID_W    = 3;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [ID_W-1:0]      rd_id = '0;
   logic [3*COORD_W-1:0] rd_center;
   logic [COORD_W-1:0]   rd_r2;
   logic [MAT_W-1:0]     rd_mat;
   logic                 rd_hit;
   logic                 wr_en = 1'b0;
   logic [ID_W-1:0]      wr_id = '0;
   logic [3*COORD_W-1:0] wr_center = '0;
   logic [COORD_W-1:0]   wr_r2 = '0;
   logic [MAT_W-1:0]     wr_mat = '0;
   logic                 wr_enable = 1'b0;
   logic                 scan_start = 1'b0;
   logic                 scan_busy;
   logic                 scan_done;
   logic                 s_valid;
   logic                 s_ready = 1'b0;
   logic [ID_W-1:0]      s_id;
   logic [3*COORD_W-1:0] s_center;
   logic [COORD_W-1:0]   s_r2;
   logic [MAT_W-1:0]     s_mat;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference table and the read result it predicts for the last edge.
   logic [3*COORD_W-1:0] m_center [N_OBJ];
   logic [COORD_W-1:0]   m_r2     [N_OBJ];
   logic [MAT_W-1:0]     m_mat    [N_OBJ];
   bit                   m_en     [N_OBJ];
   logic [3*COORD_W-1:0] exp_center;
   logic [COORD_W-1:0]   exp_r2;
   logic [MAT_W-1:0]     exp_mat;
   logic                 exp_hit;
   int                   exp_q[$];

   scene_object_table dut (
      .clk        (clk),
      .rst        (rst),
      .rd_id      (rd_id),
      .rd_center  (rd_center),
      .rd_r2      (rd_r2),
      .rd_mat     (rd_mat),
      .rd_hit     (rd_hit),
      .wr_en      (wr_en),
      .wr_id      (wr_id),
      .wr_center  (wr_center),
      .wr_r2      (wr_r2),
      .wr_mat     (wr_mat),
      .wr_enable  (wr_enable),
      .scan_start (scan_start),
      .scan_busy  (scan_busy),
      .scan_done  (scan_done),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_id       (s_id),
      .s_center   (s_center),
      .s_r2       (s_r2),
      .s_mat      (s_mat)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      for (int i = 0; i < N_OBJ; i++) begin
         m_center[i] = '0;
         m_r2[i]     = '0;
         m_mat[i]    = '0;
         m_en[i]     = 1'b0;
      end
      m_r2[0] = 32'd1 << 24;  m_en[0] = 1'b1;
      m_center[1] = {64'd0, 32'd2 << 24};    m_r2[1] = 32'd1 << 23; m_mat[1] = 3'd1; m_en[1] = 1'b1;
      m_center[2] = {64'd0, -(32'd2 << 24)}; m_r2[2] = 32'd1 << 23; m_mat[2] = 3'd2; m_en[2] = 1'b1;
   endtask

   task automatic apply_reset();
      wr_en = 1'b0; scan_start = 1'b0; s_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One clock: predict the read from the pre-edge table, then commit any write.
   task automatic step();
      @(posedge clk);
      if (m_en[rd_id]) begin
         exp_center = m_center[rd_id]; exp_r2 = m_r2[rd_id]; exp_mat = m_mat[rd_id]; exp_hit = 1'b1;
      end else begin
         exp_center = '1; exp_r2 = '1; exp_mat = '1; exp_hit = 1'b0;
      end
      if (wr_en) begin
         m_center[wr_id] = wr_center;
         m_r2[wr_id]     = wr_r2;
         m_mat[wr_id]    = wr_mat;
         m_en[wr_id]     = wr_enable;
      end
      @(negedge clk);
   endtask

   task automatic rand_write(input int id, input bit en);
      wr_en = 1'b1; wr_id = ID_W'(id);
      wr_center = {$urandom, $urandom, $urandom};
      wr_r2 = $urandom; wr_mat = MAT_W'($urandom); wr_enable = en;
   endtask

   // Accept beats against exp_q until scan_done, within a cycle budget.
   task automatic run_stream(input int budget, input bit rand_ready, input string name);
      bit done_seen = 1'b0;
      for (int c = 0; c < budget && !done_seen; c++) begin
         s_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (s_valid && s_ready) begin
            vec_cnt++;
            if (exp_q.size() == 0) begin
               err_cnt++;
               $display("FAIL %s: unexpected beat id=%0d, expected no more beats", name, s_id);
            end else begin
               int id = exp_q.pop_front();
               if (s_id !== ID_W'(id) || s_center !== m_center[id] || s_r2 !== m_r2[id] || s_mat !== m_mat[id]) begin
                  err_cnt++;
                  $display("FAIL %s: got id=%0d c=%h r2=%h mat=%0d, expected id=%0d c=%h r2=%h mat=%0d",
                           name, s_id, s_center, s_r2, s_mat, id, m_center[id], m_r2[id], m_mat[id]);
               end
            end
         end
         if (scan_done) done_seen = 1'b1;
         else step();
      end
      vec_cnt++;
      if (!done_seen || exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL %s_end: done=%0b left=%0d, expected done=1 left=0", name, done_seen, exp_q.size());
      end
      s_ready = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      vec_cnt++;
      if (rd_center !== '0 || rd_r2 !== 32'h0100_0000 || rd_mat !== 3'd0 || rd_hit !== 1'b1) begin
         err_cnt++;
         $display("FAIL reset_rd: got c=%h r2=%h mat=%0d hit=%b, expected c=0 r2=01000000 mat=0 hit=1",
                  rd_center, rd_r2, rd_mat, rd_hit);
      end
      vec_cnt++;
      if (s_valid !== 1'b0 || scan_busy !== 1'b0 || scan_done !== 1'b0 || s_id !== '0 || s_center !== '0 ||
          s_r2 !== '0 || s_mat !== '0) begin
         err_cnt++;
         $display("FAIL reset_scan: got v=%b busy=%b done=%b id=%0d, expected all 0", s_valid, scan_busy, scan_done, s_id);
      end
   endtask

   task automatic test_read_default();
      rd_id = 3'd1;
      step();
      vec_cnt++;
      if (rd_center !== {64'd0, 32'h0200_0000} || rd_r2 !== 32'h0080_0000 || rd_mat !== 3'd1 || rd_hit !== 1'b1) begin
         err_cnt++;
         $display("FAIL read_id1: got c=%h r2=%h mat=%0d hit=%b, expected x=02000000 r2=00800000 mat=1 hit=1",
                  rd_center, rd_r2, rd_mat, rd_hit);
      end
      rd_id = 3'd2;
      step();
      vec_cnt++;
      if (rd_center !== {64'd0, 32'hFE00_0000} || rd_mat !== 3'd2 || rd_hit !== 1'b1) begin
         err_cnt++;
         $display("FAIL read_id2: got c=%h mat=%0d hit=%b, expected x=fe000000 mat=2 hit=1", rd_center, rd_mat, rd_hit);
      end
      rd_id = 3'd5;
      step();
      vec_cnt++;
      if (rd_center !== {96{1'b1}} || rd_r2 !== 32'hFFFF_FFFF || rd_mat !== 3'h7 || rd_hit !== 1'b0) begin
         err_cnt++;
         $display("FAIL read_id5: got c=%h r2=%h mat=%0d hit=%b, expected all-ones hit=0", rd_center, rd_r2, rd_mat, rd_hit);
      end
   endtask

   task automatic test_write_rbw();
      rd_id = 3'd5;
      wr_en = 1'b1; wr_id = 3'd5; wr_center = {64'd0, 32'h0100_0000};
      wr_r2 = 32'h0100_0000; wr_mat = 3'd4; wr_enable = 1'b1;
      step();
      wr_en = 1'b0;
      vec_cnt++;
      if (rd_center !== {96{1'b1}} || rd_hit !== 1'b0) begin
         err_cnt++;
         $display("FAIL rbw_old: got c=%h hit=%b, expected all-ones hit=0", rd_center, rd_hit);
      end
      step();
      vec_cnt++;
      if (rd_center !== {64'd0, 32'h0100_0000} || rd_r2 !== 32'h0100_0000 || rd_mat !== 3'd4 || rd_hit !== 1'b1) begin
         err_cnt++;
         $display("FAIL rbw_new: got c=%h r2=%h mat=%0d hit=%b, expected x=01000000 r2=01000000 mat=4 hit=1",
                  rd_center, rd_r2, rd_mat, rd_hit);
      end
   endtask

   task automatic test_random_rw();
      for (int n = 0; n < 40; n++) begin
         rd_id = ID_W'($urandom_range(0, N_OBJ - 1));
         rand_write($urandom_range(0, N_OBJ - 1), 1'($urandom));
         wr_en = 1'($urandom);
         step();
         vec_cnt++;
         if (rd_center !== exp_center || rd_r2 !== exp_r2 || rd_mat !== exp_mat || rd_hit !== exp_hit) begin
            err_cnt++;
            $display("FAIL random_rw[%0d]: got c=%h r2=%h mat=%0d hit=%b, expected c=%h r2=%h mat=%0d hit=%b",
                     n, rd_center, rd_r2, rd_mat, rd_hit, exp_center, exp_r2, exp_mat, exp_hit);
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic test_scan_timing();
      bit ev, ed, eb;
      int eid;
      apply_reset();
      s_ready = 1'b1;
      scan_start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         step();
         scan_start = 1'b0;
         ev  = (c == 2 || c == 4 || c == 6);
         ed  = (c == 12);
         eb  = (c <= 11);
         eid = c / 2 - 1;
         vec_cnt++;
         if (s_valid !== ev || scan_done !== ed || scan_busy !== eb ||
             (ev && (s_id !== ID_W'(eid) || s_center !== m_center[eid] || s_r2 !== m_r2[eid] || s_mat !== m_mat[eid]))) begin
            err_cnt++;
            $display("FAIL scan_timing[t+%0d]: got v=%b done=%b busy=%b id=%0d, expected v=%b done=%b busy=%b id=%0d",
                     c, s_valid, scan_done, scan_busy, s_id, ev, ed, eb, eid);
         end
      end
      s_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int w;
      logic [3*COORD_W-1:0] o_center;
      logic [COORD_W-1:0]   o_r2;
      logic [MAT_W-1:0]     o_mat;
      apply_reset();
      scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      for (w = 0; w < 10 && s_valid !== 1'b1; w++) step();
      vec_cnt++;
      if (s_valid !== 1'b1 || s_id !== 3'd0 || s_center !== m_center[0]) begin
         err_cnt++;
         $display("FAIL bp_first: got v=%b id=%0d, expected v=1 id=0", s_valid, s_id);
      end
      s_ready = 1'b1;
      step();
      s_ready = 1'b0;
      for (w = 0; w < 10 && s_valid !== 1'b1; w++) step();
      o_center = m_center[1]; o_r2 = m_r2[1]; o_mat = m_mat[1];
      for (int h = 0; h < 5; h++) begin
         if (h == 1) rand_write(1, 1'b1);
         if (h == 2) rand_write(4, 1'b1);
         step();
         wr_en = 1'b0;
         vec_cnt++;
         if (s_valid !== 1'b1 || s_id !== 3'd1 || s_center !== o_center || s_r2 !== o_r2 || s_mat !== o_mat) begin
            err_cnt++;
            $display("FAIL bp_hold[%0d]: got v=%b id=%0d c=%h r2=%h, expected v=1 id=1 c=%h r2=%h",
                     h, s_valid, s_id, s_center, s_r2, o_center, o_r2);
         end
      end
      s_ready = 1'b1;
      step();
      exp_q = '{2, 4};
      run_stream(40, 1'b0, "bp_stream");
   endtask

   task automatic test_empty_scan();
      apply_reset();
      for (int i = 0; i < N_OBJ; i++) begin
         rand_write(i, 1'b0);
         step();
      end
      wr_en = 1'b0;
      s_ready = 1'b1;
      scan_start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         scan_start = 1'b0;
         vec_cnt++;
         if (s_valid !== 1'b0 || scan_done !== (c == N_OBJ + 1) || scan_busy !== (c <= N_OBJ)) begin
            err_cnt++;
            $display("FAIL empty_scan[t+%0d]: got v=%b done=%b busy=%b, expected v=0 done=%b busy=%b",
                     c, s_valid, scan_done, scan_busy, c == N_OBJ + 1, c <= N_OBJ);
         end
      end
      s_ready = 1'b0;
   endtask

   task automatic test_random_scan();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < N_OBJ; i++) begin
            rand_write(i, 1'($urandom));
            step();
         end
         wr_en = 1'b0;
         exp_q.delete();
         for (int i = 0; i < N_OBJ; i++) if (m_en[i]) exp_q.push_back(i);
         scan_start = 1'b1;
         step();
         scan_start = 1'b0;
         run_stream(200, 1'b1, $sformatf("rand_scan%0d", r));
      end
   endtask

   task automatic test_reset_in_hold();
      int w;
      apply_reset();
      scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      for (w = 0; w < 10 && s_valid !== 1'b1; w++) step();
      vec_cnt++;
      if (s_valid !== 1'b1 || scan_busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL rst_hold_pre: got v=%b busy=%b, expected v=1 busy=1", s_valid, scan_busy);
      end
      #2 rst = 1'b1;
      #1;
      vec_cnt++;
      if (s_valid !== 1'b0 || scan_busy !== 1'b0 || scan_done !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_hold_async: got v=%b busy=%b done=%b, expected 0 0 0", s_valid, scan_busy, scan_done);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      rd_id = 3'd0;
      step();
      vec_cnt++;
      if (rd_center !== exp_center || rd_r2 !== exp_r2 || rd_mat !== exp_mat || rd_hit !== exp_hit ||
          s_valid !== 1'b0 || scan_busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_hold_read0: got c=%h r2=%h mat=%0d hit=%b v=%b, expected c=%h r2=%h mat=%0d hit=%b v=0",
                  rd_center, rd_r2, rd_mat, rd_hit, s_valid, exp_center, exp_r2, exp_mat, exp_hit);
      end
   endtask

   initial begin
      test_reset();
      test_read_default();
      test_write_rbw();
      test_random_rw();
      test_scan_timing();
      test_backpressure();
      test_empty_scan();
      test_random_scan();
      test_reset_in_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire
